// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state types for the JK sequence controller and its bench.
package jk_seq_pkg;

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_CLEAR  = 3'd1,
    OP_SET    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_TOGGLE = 3'd4,
    OP_CNT_UP = 3'd5,
    OP_CNT_DN = 3'd6,
    OP_RSVD   = 3'd7
  } jk_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } jk_state_e;

  function automatic logic is_count_op(input jk_op_e op);
    return (op == OP_CNT_UP) || (op == OP_CNT_DN);
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop: hold/reset/set/toggle on the rising edge, sync active-high reset.
// Latency: one edge from J/K to q; no flow control.
module jk_cell (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_j,
  input  logic i_k,
  output logic o_q,
  output logic o_qbar
);

  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q <= 1'b0;
    end else begin
      case ({i_j, i_k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign o_q    = r_q;
  assign o_qbar = ~r_q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// Sequences WIDTH JK cells through one command at a time (IDLE->EXEC->DONE); done 2 cycles after accept, N+1 for N-step counts.
// Accepts only in IDLE (valid/ready, no queueing); JK_SEQ_SAT_EN makes counts saturate and end early at the limit.
module jk_seq_ctrl
  import jk_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [WIDTH-1:0]  cmd_data,
  input  logic [STEP_W-1:0] cmd_steps,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              busy,
  output logic              done
);

  jk_state_e         r_state;
  jk_state_e         w_state_nxt;
  jk_op_e            r_op;
  logic [WIDTH-1:0]  r_data;
  logic [STEP_W-1:0] r_steps;

  logic              w_accept;
  logic              w_cnt;
  logic              w_step;
  logic              w_last;
  logic              w_carry;
  logic [WIDTH-1:0]  w_src;
  logic [WIDTH-1:0]  w_t;
  logic [WIDTH-1:0]  w_j;
  logic [WIDTH-1:0]  w_k;

  assign cmd_ready = (r_state == IDLE) & ~rst;
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_cnt     = is_count_op(r_op);
  assign busy      = (r_state == EXEC);
  assign done      = (r_state == DONE);

  // Ripple-carry toggle enables: counting down is counting up on the inverted outputs.
  always_comb begin
    w_src   = (r_op == OP_CNT_DN) ? qbar : q;
    w_t     = '0;
    w_carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      w_t[i]  = w_carry;
      w_carry = w_carry & w_src[i];
    end
  end

`ifdef JK_SEQ_SAT_EN
  logic w_at_lim;
  logic w_near_lim;

  assign w_at_lim   = (r_op == OP_CNT_DN) ? (q == '0) : (q == '1);
  assign w_near_lim = (r_op == OP_CNT_DN) ? (q == WIDTH'(1)) : (q == ~WIDTH'(1));
  assign w_step     = w_cnt && (r_steps != '0) && !w_at_lim;
  assign w_last     = !w_cnt || (r_steps <= STEP_W'(1)) || w_at_lim || w_near_lim;
`else
  assign w_step     = w_cnt && (r_steps != '0);
  assign w_last     = !w_cnt || (r_steps <= STEP_W'(1));
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_j         = '0;
    w_k         = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = EXEC;
      end
      EXEC: begin
        case (r_op)
          OP_CLEAR:  w_k = '1;
          OP_SET:    w_j = '1;
          OP_LOAD: begin
            w_j = r_data;
            w_k = ~r_data;
          end
          OP_TOGGLE: begin
            w_j = r_data;
            w_k = r_data;
          end
          OP_CNT_UP, OP_CNT_DN: begin
            if (w_step) begin
              w_j = w_t;
              w_k = w_t;
            end
          end
          default: ;
        endcase
        if (w_last) w_state_nxt = DONE;
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Step counter is cleared on leaving EXEC so an early saturation exit discards the remainder.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_data  <= '0;
      r_steps <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op    <= jk_op_e'(cmd_op);
        r_data  <= cmd_data;
        r_steps <= cmd_steps;
      end else if (r_state == EXEC) begin
        r_steps <= w_last ? '0 : (r_steps - STEP_W'(1));
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_j    (w_j[gi]),
      .i_k    (w_k[gi]),
      .o_q    (q[gi]),
      .o_qbar (qbar[gi])
    );
  end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Bench for jk_seq_ctrl: table of commands plus hand sequences for counts, busy-drop and mid-command reset.
module tb_jk_seq_ctrl;
  import jk_seq_pkg::*;

  localparam int W  = 4;
  localparam int SW = 8;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op    = '0;
  logic [W-1:0]  cmd_data  = '0;
  logic [SW-1:0] cmd_steps = '0;
  logic          cmd_ready;
  logic [W-1:0]  q;
  logic [W-1:0]  qbar;
  logic          busy;
  logic          done;

  jk_seq_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_steps (cmd_steps),
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tot  = 0;
  int n_pass = 0;

  typedef struct {
    logic [W-1:0] q;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  typedef struct {
    jk_op_e        op;
    logic [W-1:0]  d;
    logic [SW-1:0] st;
    logic [W-1:0]  eq;
    int            lat;
    string         nm;
  } vec_t;

  exp_t sb[$];
  exp_t m_e;
  logic [W-1:0] m_inv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        m_e   = sb.pop_front();
        m_inv = ~q;
        chk({m_e.name, "_q"}, 32'(q), 32'(m_e.q));
        chk({m_e.name, "_lat"}, 32'(cyc - m_e.acc), 32'(m_e.lat));
        chk({m_e.name, "_qbar"}, 32'(qbar), 32'(m_inv));
      end
    end
  end

  task automatic issue(input string nm, input jk_op_e op, input logic [W-1:0] d,
                       input logic [SW-1:0] st, input logic [W-1:0] eq, input int lat);
    int   t;
    exp_t e;
    t = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      chk({nm, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    end else begin
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      cmd_steps = st;
      e.q    = eq;
      e.lat  = lat;
      e.acc  = cyc;
      e.name = nm;
      sb.push_back(e);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
    @(negedge clk);
    chk({nm, "_ready_after"}, 32'(cmd_ready), 32'd1);
  endtask

  vec_t         tbl[10];
  logic [W-1:0] up_seq[3];

  initial begin
    tbl[0] = '{OP_LOAD,   4'b1010, 8'd0, 4'b1010, 2, "load_a"};
    tbl[1] = '{OP_TOGGLE, 4'b0110, 8'd0, 4'b1100, 2, "toggle_6"};
    tbl[2] = '{OP_CLEAR,  4'b0000, 8'd0, 4'b0000, 2, "clear"};
    tbl[3] = '{OP_SET,    4'b0000, 8'd0, 4'b1111, 2, "set"};
    tbl[4] = '{OP_HOLD,   4'b0101, 8'd0, 4'b1111, 2, "hold"};
    tbl[5] = '{OP_RSVD,   4'b0101, 8'd0, 4'b1111, 2, "rsvd"};
    tbl[6] = '{OP_LOAD,   4'b0101, 8'd0, 4'b0101, 2, "load_5"};
    tbl[7] = '{OP_CNT_DN, 4'b0000, 8'd2, 4'b0011, 3, "cntdn2"};
    tbl[8] = '{OP_CNT_UP, 4'b0000, 8'd1, 4'b0100, 2, "cntup1"};
    tbl[9] = '{OP_LOAD,   4'b1110, 8'd0, 4'b1110, 2, "load_e"};

    // Reset held for two edges.
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready_low", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qbar", 32'(qbar), 32'hF);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_ready", 32'(cmd_ready), 32'd1);

    foreach (tbl[i]) begin
      issue(tbl[i].nm, tbl[i].op, tbl[i].d, tbl[i].st, tbl[i].eq, tbl[i].lat);
      drain(tbl[i].nm);
    end

    // 1110 counting up three steps.
`ifdef JK_SEQ_SAT_EN
    up_seq = '{4'b1111, 4'b1111, 4'b1111};
    issue("cntup3", OP_CNT_UP, 4'b0000, 8'd3, 4'b1111, 2);
`else
    up_seq = '{4'b1111, 4'b0000, 4'b0001};
    issue("cntup3", OP_CNT_UP, 4'b0000, 8'd3, 4'b0001, 4);
`endif
    @(negedge clk);
    chk("cntup3_busy", 32'(busy), 32'd1);
    chk("cntup3_q0", 32'(q), 32'hE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("cntup3_seq%0d", i), 32'(q), 32'(up_seq[i]));
    end
    drain("cntup3");

    // Zero-step count, with a command offered while busy.
    issue("load_0", OP_LOAD, 4'b0000, 8'd0, 4'b0000, 2);
    drain("load_0");
    issue("cntdn0", OP_CNT_DN, 4'b0000, 8'd0, 4'b0000, 2);
    @(negedge clk);
    chk("cntdn0_busy", 32'(busy), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = OP_SET;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    drain("cntdn0");
    repeat (3) @(negedge clk);
    chk("busy_cmd_ignored_q", 32'(q), 32'h0);
    chk("busy_cmd_ignored_busy", 32'(busy), 32'd0);

    // Reset in the middle of a long count.
    issue("cntup10", OP_CNT_UP, 4'b0000, 8'd10, 4'b0000, 11);
    @(negedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("cntup10_step%0d", i), 32'(q), 32'(i));
    end
    rst = 1'b1;
    #1;
    chk("midrst_ready_low", 32'(cmd_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_nodone%0d", i), 32'(done), 32'd0);
    end
    chk("midrst_q_held", 32'(q), 32'h0);
    issue("post_rst_set", OP_SET, 4'b0000, 8'd0, 4'b1111, 2);
    drain("post_rst_set");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_tot);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/jk_seq_ctrl.md
JK_SEQ_CTRL -- requirements
Module: jk_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of JK cells controlled.
REQ-002 The block SHALL have parameter STEP_W, default 8, giving the width of the step count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 The block SHALL have port cmd_ready, output, 1 bit: the controller can accept a command.
REQ-007 The block SHALL have port cmd_op, input, 3 bits: opcode; 0 HOLD, 1 CLEAR, 2 SET, 3 LOAD, 4 TOGGLE, 5 CNT_UP, 6 CNT_DN, 7 reserved.
REQ-008 The block SHALL have port cmd_data, input, WIDTH bits: load value or toggle mask.
REQ-009 The block SHALL have port cmd_steps, input, STEP_W bits: count cycles for CNT_UP and CNT_DN.
REQ-010 The block SHALL have port q, output, WIDTH bits: JK cell outputs.
REQ-011 The block SHALL have port qbar, output, WIDTH bits: always the bitwise inverse of q.
REQ-012 The block SHALL have port busy, output, 1 bit: high in EXEC.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse on command completion.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL occur at the edge where cmd_valid and cmd_ready are both 1; op, data and steps SHALL be latched and the state SHALL go IDLE->EXEC.
REQ-016 In EXEC, each cell SHALL receive J/K per the latched op: HOLD J=K=0; CLEAR J=0,K=1; SET J=1,K=0; LOAD J=data,K=~data; TOGGLE J=K=data.
REQ-017 Single-cycle ops (0-4, and 7 treated as HOLD) SHALL update q at the first edge in EXEC, then go EXEC->DONE.
REQ-018 For CNT_UP, bit i SHALL get J=K=AND of q[i-1:0], with bit 0 J=K=1; for CNT_DN, the same rule SHALL use qbar; each EXEC cycle is one count step.
REQ-019 For a count op, the remaining-step counter SHALL load cmd_steps, decrement per step, and leave EXEC after the step that takes it to 0.
REQ-020 A count op with cmd_steps=0 SHALL change nothing and go EXEC->DONE after one cycle.
REQ-021 Without saturation, counts SHALL wrap modulo 2^WIDTH: all-ones+1=0 and 0-1=all-ones.
REQ-022 done SHALL be 1 for exactly the one cycle spent in DONE; DONE SHALL then go to IDLE unconditionally.
REQ-023 cmd_valid while not ready SHALL be ignored; the command is not queued.
REQ-024 Command latency SHALL be 1 edge for q to update plus 1 cycle to done, i.e. done appears 2 cycles after acceptance; for counts of N>0 steps, done appears N+1 cycles after acceptance.

Reset
REQ-025 While rst=1 at an edge: q=0, qbar=all ones, state=IDLE, step counter=0, busy=0, done=0.
REQ-026 cmd_ready SHALL be 0 during any cycle rst=1 and 1 from the first cycle after release.
REQ-027 Reset mid-command SHALL abort without a done pulse; the aborted command SHALL not resume.

Configuration
REQ-028 With macro JK_SEQ_SAT_EN defined, CNT_UP SHALL stop at all-ones and CNT_DN at zero; reaching the limit SHALL end EXEC immediately (remaining steps discarded) with the normal done pulse.
REQ-029 Without JK_SEQ_SAT_EN, the wrap behaviour of REQ-021 SHALL apply and no saturation logic SHALL be present.

Structure
REQ-030 Package jk_seq_pkg SHALL hold the opcode enum (3 bits) and the FSM state enum.
REQ-031 One sub-module, jk_cell, SHALL implement a single JK flip-flop with q/qbar and the synchronous reset of REQ-025 (hold/reset/set/toggle truth table); it SHALL be instantiated WIDTH times.

Verification
REQ-032 The bench SHALL check: rst for 2 cycles -> q=0000, qbar=1111, cmd_ready=1 after release, done=0.
REQ-033 The bench SHALL check: LOAD data=1010 -> q=1010 one edge after acceptance, done pulse on the next cycle, cmd_ready back to 1.
REQ-034 The bench SHALL check: q=1010, TOGGLE mask=0110 -> q=1100; CLEAR -> 0000; SET -> 1111.
REQ-035 The bench SHALL check: q=1110, CNT_UP steps=3 -> q sequence 1111, 0000, 0001 and done 4 cycles after acceptance; with JK_SEQ_SAT_EN -> q=1111 held and done early.
REQ-036 The bench SHALL check: q=0000, CNT_DN steps=0 -> q unchanged and done 2 cycles after acceptance; a cmd_valid pulse during busy is ignored.
REQ-037 The bench SHALL check: CNT_UP steps=10 with rst asserted at step 4 -> q=0000, no done pulse, and the next command is accepted normally.
